rr_priority_arbiter: RTL and testbench
======================================

# rr_priority_arbiter

Parametrised N-requester arbiter extending the 4-input combinational priority encoder into a registered, handshaked grant unit. Each cycle it picks one requester by fixed priority (highest index wins) or round-robin, registers the grant, and holds it until the grantee signals `done`. It sits in front of any shared resource (bus, memory port, result register) contended by several producers.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal values are ≥2.
- `ROUND_ROBIN`, default 1: 1 selects round-robin, 0 selects fixed priority (highest index wins).
- `IDX_W`, default `$clog2(NUM_REQ)`: grant index width; derived, never overridden.

Ports, clock and reset first:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NUM_REQ`: request vector; bit i is requester i.
- `done` in 1: the current grantee releases the resource; ignored when `gnt_valid`=0.
- `gnt` out `NUM_REQ`: registered one-hot grant; all zeros when idle.
- `gnt_idx` out `IDX_W`: registered binary index of the grantee; 0 when idle.
- `gnt_valid` out 1: registered; high while a grant is held.

## Operation
- **Reset values:** `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, state IDLE, `last_idx`=`NUM_REQ`-1.
- **States:** IDLE and BUSY.
- **IDLE:**
  - `req`≠0: register the winner, go to BUSY, and set `last_idx` to the winner.
  - `req`=0: stay in IDLE.
- **BUSY:**
  - The grant is frozen while `done`=0. Changes on `req` are ignored, including the grantee dropping its own request.
  - `done`=1 and `req`≠0: register the new winner from the current `req`, stay in BUSY, and update `last_idx`. There is no idle gap.
  - `done`=1 and `req`=0: go to IDLE and clear the outputs.
- **Fixed mode:** the winner is the highest set bit of `req`, with MSB as top priority. `last_idx` is tracked but unused.
- **Round-robin mode:**
  - Priority order is `last_idx`+1, `last_idx`+2, … modulo `NUM_REQ`, so `last_idx` itself has lowest priority.
  - The grantee may win again if it is the only requester.
  - Implementation: mask `req` to bits with index > `last_idx`. If the masked vector is nonzero, take its lowest set bit; otherwise take the lowest set bit of the unmasked `req`.
- **Output relations:** `gnt` is always one-hot or zero, `gnt` = 1 << `gnt_idx` when valid, and `gnt_valid` = |`gnt`.
- **Reset mid-BUSY:** `rst` has priority over everything, including a simultaneous `done` or `req`.

## Timing
- **Latency:** a request sampled at edge t appears as a grant after edge t (one cycle). Outputs never depend combinationally on `req` or `done`.
- **Handover:** `done` high in cycle t moves the grant to the new winner in cycle t+1. A requester can therefore hold the resource for a minimum of one cycle.
- **Reset:** `rst` high in cycle t gives reset outputs in cycle t+1.
- **Throughput:** with `done` held high and all requesters active, one new grant per cycle.

## Structure
- **Package `arbiter_pkg`:** contains `state_t` (IDLE, BUSY) and the mode constants `ARB_FIXED`=0 and `ARB_RR`=1.
- **Sub-module `priority_encoder_n`:** combinational, parameters `NUM_IN` and `LSB_FIRST`; outputs `result[$clog2(NUM_IN)]` and `valid`.
  - Fixed mode uses one instance with MSB-first priority.
  - Round-robin mode uses two LSB-first instances, one for the masked vector and one for the unmasked vector.
- **Top level:** FSM, `last_idx` register, mask generation, output registers.

## Test plan
All scenarios use `NUM_REQ`=4.
- **Reset:** hold `rst` for 2 cycles with `req`=4'b1111 → `gnt`=0, `gnt_idx`=0, `gnt_valid`=0. The first grant after release (round-robin) is `gnt`=4'b0001.
- **Fixed mode, hold and handover:**
  - `req`=4'b0110 → next cycle `gnt`=4'b0100, `gnt_idx`=2.
  - Change `req` to 4'b1111 with `done`=0 for 3 cycles → grant held at 4'b0100.
  - Pulse `done` → `gnt`=4'b1000.
- **Round-robin rotation:** `req`=4'b1111 with `done` held high → `gnt_idx` sequence 0,1,2,3,0,1 on consecutive cycles.
- **Round-robin skip and wrap:**
  - After a grant to 1, `req`=4'b1001 → `gnt_idx`=3.
  - `done` with `req`=4'b0001 → `gnt_idx`=0.
- **Release to idle:**
  - `done` with `req`=0 → `gnt_valid`=0 next cycle.
  - Then `req`=4'b0100 → `gnt_idx`=2 one cycle later.
- **Reset mid-BUSY:**
  - While grant 2 is held, assert `rst` together with `done` and `req`=4'b1111 → cleared outputs next cycle.
  - After release → `gnt_idx`=0, confirming `last_idx` was reset.

Source files
------------

// File: rtl/rr_priority_arbiter_pkg.sv
// Shared types and mode constants for the registered N-requester arbiter.
package arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/rr_priority_arbiter_enc.sv
// Combinational N-input priority encoder; LSB_FIRST selects lowest or highest
// set bit as the winner.
module priority_encoder_n #(
  parameter int NUM_IN    = 4,
  parameter bit LSB_FIRST = 1'b1,
  localparam int W        = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] vec,
  output logic [W-1:0]      result,
  output logic              valid
);

  always_comb begin
    result = '0;
    valid  = |vec;
    // Scan from lowest to highest priority so the last hit is the winner.
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (LSB_FIRST) begin
        if (vec[NUM_IN-1-i]) result = W'(NUM_IN - 1 - i);
      end else begin
        if (vec[i]) result = W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered, handshaked N-requester arbiter: fixed (MSB wins) or round-robin
// selection, grant held until the grantee signals done.
module rr_priority_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ROUND_ROBIN = 1,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  state_t           state;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;

  assign win_valid = |req;

  if (ROUND_ROBIN == ARB_RR) begin : g_rr
    logic [NUM_REQ-1:0] mask;
    logic [IDX_W-1:0]   masked_idx;
    logic [IDX_W-1:0]   plain_idx;
    logic               masked_valid;
    logic               plain_valid;

    always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        mask[i] = IDX_W'(i) > last_idx;
      end
    end

    priority_encoder_n #(
      .NUM_IN    (NUM_REQ),
      .LSB_FIRST (1'b1)
    ) u_enc_masked (
      .vec    (req & mask),
      .result (masked_idx),
      .valid  (masked_valid)
    );

    priority_encoder_n #(
      .NUM_IN    (NUM_REQ),
      .LSB_FIRST (1'b1)
    ) u_enc_plain (
      .vec    (req),
      .result (plain_idx),
      .valid  (plain_valid)
    );

    // Unmasked search only wins when nobody above last_idx is requesting.
    assign win_idx = masked_valid ? masked_idx : plain_idx;
  end else begin : g_fixed
    logic fixed_valid;

    priority_encoder_n #(
      .NUM_IN    (NUM_REQ),
      .LSB_FIRST (1'b0)
    ) u_enc_fixed (
      .vec    (req),
      .result (win_idx),
      .valid  (fixed_valid)
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      last_idx  <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state     <= BUSY;
            gnt       <= NUM_REQ'(1) << win_idx;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            last_idx  <= win_idx;
          end
        end
        BUSY: begin
          if (done) begin
            if (win_valid) begin
              gnt       <= NUM_REQ'(1) << win_idx;
              gnt_idx   <= win_idx;
              last_idx  <= win_idx;
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_idx   <= '0;
              gnt_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench: table of round-robin vectors plus a fixed-priority
// hold/handover sequence, each applied for one cycle and checked after the edge.
module tb_rr_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_rr, rst_fx;
  logic [3:0] req_rr, req_fx;
  logic       done_rr, done_fx;
  logic [3:0] gnt_rr, gnt_fx;
  logic [1:0] idx_rr, idx_fx;
  logic       valid_rr, valid_fx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_priority_arbiter #(
    .NUM_REQ     (4),
    .ROUND_ROBIN (1)
  ) u_rr (
    .clk       (clk),
    .rst       (rst_rr),
    .req       (req_rr),
    .done      (done_rr),
    .gnt       (gnt_rr),
    .gnt_idx   (idx_rr),
    .gnt_valid (valid_rr)
  );

  rr_priority_arbiter #(
    .NUM_REQ     (4),
    .ROUND_ROBIN (0)
  ) u_fx (
    .clk       (clk),
    .rst       (rst_fx),
    .req       (req_fx),
    .done      (done_fx),
    .gnt       (gnt_fx),
    .gnt_idx   (idx_fx),
    .gnt_valid (valid_fx)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [3:0] ag, input logic [1:0] ai,
                       input logic av, input logic [3:0] eg, input logic [1:0] ei,
                       input logic ev);
    total++;
    if (ag !== eg || ai !== ei || av !== ev) begin
      bad++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b, want gnt=%b idx=%0d valid=%b",
               name, ag, ai, av, eg, ei, ev);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fx_step(input logic [3:0] r, input logic d, input string name,
                         input logic [3:0] eg, input logic [1:0] ei, input logic ev);
    req_fx  = r;
    done_fx = d;
    tick();
    check(name, gnt_fx, idx_fx, valid_fx, eg, ei, ev);
  endtask

  initial begin
    //          rst   req      done  gnt      idx    valid
    tbl[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1}; // first grant after reset
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[6]  = '{1'b0, 4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1}; // skip 2
    tbl[7]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1}; // wrap
    tbl[8]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0}; // release to idle
    tbl[9]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[10] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1}; // frozen
    tbl[11] = '{1'b0, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1}; // grantee drops req
    tbl[12] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0}; // reset mid-busy
    tbl[13] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1}; // last_idx was reset
    tbl[14] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
    tbl[15] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1}; // sole requester re-wins
    tbl[16] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[17] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0}; // done ignored when idle

    rst_rr = 1'b1; req_rr = 4'b1111; done_rr = 1'b0;
    rst_fx = 1'b1; req_fx = 4'b1111; done_fx = 1'b0;
    tick();
    check("rr_reset_c1", gnt_rr, idx_rr, valid_rr, 4'b0000, 2'd0, 1'b0);
    check("fx_reset_c1", gnt_fx, idx_fx, valid_fx, 4'b0000, 2'd0, 1'b0);
    tick();
    check("rr_reset_c2", gnt_rr, idx_rr, valid_rr, 4'b0000, 2'd0, 1'b0);
    check("fx_reset_c2", gnt_fx, idx_fx, valid_fx, 4'b0000, 2'd0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      rst_rr  = tbl[i].rst;
      req_rr  = tbl[i].req;
      done_rr = tbl[i].done;
      tick();
      check($sformatf("rr_vec%0d", i), gnt_rr, idx_rr, valid_rr,
            tbl[i].gnt, tbl[i].idx, tbl[i].valid);
    end

    rst_fx = 1'b0;
    fx_step(4'b0110, 1'b0, "fx_first",   4'b0100, 2'd2, 1'b1);
    for (int i = 0; i < 3; i++)
      fx_step(4'b1111, 1'b0, $sformatf("fx_hold%0d", i), 4'b0100, 2'd2, 1'b1);
    fx_step(4'b1111, 1'b1, "fx_handover", 4'b1000, 2'd3, 1'b1);
    fx_step(4'b1111, 1'b0, "fx_hold_top", 4'b1000, 2'd3, 1'b1);
    fx_step(4'b0011, 1'b1, "fx_next",     4'b0010, 2'd1, 1'b1);
    fx_step(4'b1111, 1'b1, "fx_msb_wins", 4'b1000, 2'd3, 1'b1);
    fx_step(4'b0000, 1'b1, "fx_idle",     4'b0000, 2'd0, 1'b0);
    fx_step(4'b0001, 1'b0, "fx_from_idle",4'b0001, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
